// File: rtl/ula_exec_ctrl.sv
// Issue/write-back controller for the combinational ula: decodes instructions, reads
// operands from an 8x16 register file, drives registered operands, and writes the result back.
module ula_exec_ctrl #(
    parameter int DATA_W = 16,
    parameter int OPND_W = 7,
    parameter int OP_W   = 3,
    parameter int RA_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [OPND_W-1:0] alu_a,
    output logic [OPND_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              done,
    output logic              done_err,
    output logic [RA_W-1:0]   done_rd,
    output logic [DATA_W-1:0] done_result,
    input  logic [RA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int NREG = 1 << RA_W;

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SUBI = OP_W'(4);
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(5);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   rf_q [NREG];
    logic [DATA_W-1:0]   rf_d [NREG];
    logic [OP_W-1:0]     alu_opcode_q, alu_opcode_d;
    logic [OPND_W-1:0]   alu_a_q, alu_a_d;
    logic [OPND_W-1:0]   alu_b_q, alu_b_d;
    logic [RA_W-1:0]     rd_q, rd_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   result_q, result_d;

    logic [OP_W-1:0]     dec_op;
    logic [RA_W-1:0]     dec_rd, dec_rs1, dec_rs2;
    logic [OPND_W-1:0]   dec_imm;
    logic                dec_legal, dec_use_imm;

    assign dec_op  = instr[15 -: OP_W];
    assign dec_rd  = instr[12 -: RA_W];
    assign dec_rs1 = instr[9 -: RA_W];
    assign dec_rs2 = instr[6 -: RA_W];
    assign dec_imm = instr[OPND_W-1:0];

    always_comb begin
        dec_legal   = 1'b0;
        dec_use_imm = 1'b0;
        case (dec_op)
            OP_ADD, OP_SUB, OP_MUL: dec_legal = 1'b1;
            OP_ADDI, OP_SUBI: begin
                dec_legal   = 1'b1;
                dec_use_imm = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        rf_d         = rf_q;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rd_d         = rd_q;
        err_d        = err_q;
        result_d     = result_q;

        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    rd_d = dec_rd;
                    if (dec_legal) begin
                        // r0 always holds zero, so no special case is needed on reads
                        alu_opcode_d = dec_op;
                        alu_a_d      = rf_q[dec_rs1][OPND_W-1:0];
                        alu_b_d      = dec_use_imm ? dec_imm : rf_q[dec_rs2][OPND_W-1:0];
                        err_d        = 1'b0;
                        state_d      = EXEC;
                    end else begin
                        err_d    = 1'b1;
                        result_d = '0;
                        state_d  = WB;
                    end
                end
            end
            EXEC: begin
                result_d = alu_result;
                state_d  = WB;
            end
            WB: begin
                if (!err_q && (rd_q != '0)) begin
                    rf_d[rd_q] = result_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rd_q         <= '0;
            err_q        <= 1'b0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rd_q         <= rd_d;
            err_q        <= err_d;
            result_q     <= result_d;
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign alu_opcode  = alu_opcode_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign done        = (state_q == WB);
    assign done_err    = (state_q == WB) && err_q;
    assign done_rd     = rd_q;
    assign done_result = result_q;
    assign dbg_data    = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_ula_exec_ctrl.sv
// Directed bench for ula_exec_ctrl with a behavioural ula attached to the operand bus.
module tb_ula_exec_ctrl;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [2:0]  alu_opcode;
    logic [6:0]  alu_a;
    logic [6:0]  alu_b;
    logic [15:0] alu_result;
    logic        done;
    logic        done_err;
    logic [2:0]  done_rd;
    logic [15:0] done_result;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int checks = 0;
    int errors = 0;

    ula_exec_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .done        (done),
        .done_err    (done_err),
        .done_rd     (done_rd),
        .done_result (done_result),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference ula: 16-bit arithmetic on zero-extended 7-bit operands
    always_comb begin
        case (alu_opcode)
            3'b001, 3'b010: alu_result = {9'd0, alu_a} + {9'd0, alu_b};
            3'b011, 3'b100: alu_result = {9'd0, alu_a} - {9'd0, alu_b};
            3'b101:         alu_result = {9'd0, alu_a} * {9'd0, alu_b};
            default:        alu_result = 16'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [6:0] lo);
        return {op, rd, rs1, lo};
    endfunction

    function automatic logic [6:0] r2(input logic [2:0] rs2);
        return {rs2, 4'b0000};
    endfunction

    task automatic run(input string tag, input logic [15:0] ins, input int exp_lat,
                       input logic [15:0] exp_res, input logic exp_err);
        int lat;
        chk({tag, ".ready"}, instr_ready, 1'b1);
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr       = 16'hA5A5;
        lat = 1;
        while (!done && lat < 6) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".result"}, done_result, exp_res);
        chk({tag, ".err"}, done_err, exp_err);
        chk({tag, ".rd"}, done_rd, ins[12:10]);
        @(posedge clk); #1;
        chk({tag, ".done_clr"}, done, 1'b0);
    endtask

    task automatic dbg(input string tag, input logic [2:0] addr, input logic [15:0] exp);
        dbg_addr = addr;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    initial begin
        int acc;
        int dones;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0;
        dbg_addr    = 3'd0;
        #3;
        chk("rst.ready", instr_ready, 1'b1);
        chk("rst.done", done, 1'b0);
        chk("rst.alu_opcode", alu_opcode, 3'd0);
        chk("rst.done_result", done_result, 16'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;

        run("addi_r1", mk(3'd2, 3'd1, 3'd0, 7'd5), 2, 16'd5, 1'b0);
        dbg("dbg_r1", 3'd1, 16'd5);
        run("add_r2", mk(3'd1, 3'd2, 3'd1, r2(3'd1)), 2, 16'd10, 1'b0);
        dbg("dbg_r2", 3'd2, 16'd10);
        run("sub_r3", mk(3'd3, 3'd3, 3'd0, r2(3'd1)), 2, 16'hFFFB, 1'b0);
        dbg("dbg_r3a", 3'd3, 16'hFFFB);
        run("subi_r3", mk(3'd4, 3'd3, 3'd1, 7'd5), 2, 16'd0, 1'b0);
        dbg("dbg_r3b", 3'd3, 16'd0);

        run("addi_r5", mk(3'd2, 3'd5, 3'd0, 7'd127), 2, 16'd127, 1'b0);
        run("mul_r4", mk(3'd5, 3'd4, 3'd5, r2(3'd5)), 2, 16'h3F01, 1'b0);
        dbg("dbg_r4", 3'd4, 16'h3F01);
        run("add_r6", mk(3'd1, 3'd6, 3'd4, r2(3'd0)), 2, 16'd1, 1'b0);
        dbg("dbg_r6", 3'd6, 16'd1);

        run("ill_111", mk(3'd7, 3'd2, 3'd1, r2(3'd1)), 1, 16'd0, 1'b1);
        chk("ill.alu_opcode_hold", alu_opcode, 3'b001);
        chk("ill.alu_a_hold", alu_a, 7'd1);
        chk("ill.alu_b_hold", alu_b, 7'd0);
        dbg("dbg_r2_kept", 3'd2, 16'd10);
        run("ill_000", mk(3'd0, 3'd1, 3'd1, 7'd0), 1, 16'd0, 1'b1);
        dbg("dbg_r1_kept", 3'd1, 16'd5);
        run("addi_r0", mk(3'd2, 3'd0, 3'd0, 7'd9), 2, 16'd9, 1'b0);
        dbg("dbg_r0", 3'd0, 16'd0);

        // Abort an instruction in EXEC with an asynchronous reset
        instr       = mk(3'd2, 3'd7, 3'd0, 7'd3);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk("abort.in_exec", instr_ready, 1'b0);
        rst = 1'b1;
        #1;
        chk("abort.ready", instr_ready, 1'b1);
        chk("abort.done", done, 1'b0);
        chk("abort.alu_a", alu_a, 7'd0);
        @(posedge clk); #1;
        chk("abort.done_hold", done, 1'b0);
        #2;
        rst = 1'b0;
        dbg("abort.r7", 3'd7, 16'd0);
        dbg("abort.r1_cleared", 3'd1, 16'd0);

        // Valid held high: one accept every three cycles
        instr       = mk(3'd2, 3'd1, 3'd0, 7'd1);
        instr_valid = 1'b1;
        acc   = 0;
        dones = 0;
        for (int i = 0; i < 9; i++) begin
            if (instr_ready) acc++;
            @(posedge clk); #1;
            if (done) dones++;
        end
        instr_valid = 1'b0;
        chk("stream.accepts", acc, 3);
        chk("stream.dones", dones, 3);
        chk("stream.ready_end", instr_ready, 1'b1);
        dbg("stream.r1", 3'd1, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
